// File: rtl/seven_seg_display_controller.sv
// Four-digit common-anode display scanner with a shared, active-low segment bus.
// Each digit goes through SHOW then BLANK; the value is latched once per frame so digits never tear.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_SHOW  | digit digit_sel_q is lit, cnt_q runs 0..TICK_COUNT-1
//  ST_BLANK | all anodes off (dead time), cnt_q runs 0..BLANK_CYCLES-1
module seven_seg_display_controller #(
    parameter int CNT_W        = 17,
    parameter int TICK_COUNT   = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        lz_suppress,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TICK_TC  = CNT_W'(TICK_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_LAST);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [15:0]      snap_q, snap_d;
    logic             load_pending_q, load_pending_d;
    logic [3:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [1:0]       dsel_out_q, dsel_out_d;

    logic [15:0]      disp_val;
    logic [15:0]      upper_nibbles;
    logic             suppress;
    logic             advance;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        // A pending load is displayed immediately so the first lit digit already shows the new value.
        disp_val      = load_pending_q ? value : snap_q;
        upper_nibbles = disp_val >> {digit_sel_q, 2'b00};
        suppress      = lz_suppress && (digit_sel_q != 2'd0) && (upper_nibbles == 16'h0000);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        digit_sel_d    = digit_sel_q;
        snap_d         = snap_q;
        load_pending_d = load_pending_q;
        anode_d        = 4'b1111;
        seg_d          = 7'h7F;
        dp_d           = 1'b1;
        dsel_out_d     = digit_sel_q;
        advance        = 1'b0;

        if (en) begin
            if (load_pending_q) begin
                snap_d         = value;
                load_pending_d = 1'b0;
            end
            case (state_q)
                ST_SHOW: begin
                    anode_d = ~(4'b0001 << digit_sel_q);
                    seg_d   = suppress ? 7'h7F : hex_to_seg(upper_nibbles[3:0]);
                    dp_d    = ~dp_mask[digit_sel_q];
                    if (cnt_q == TICK_TC) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES == 0) advance = 1'b1;
                        else                   state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt_q == BLANK_TC) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
            // Entering digit 0 starts a new frame: take a fresh snapshot.
            if (advance) begin
                digit_sel_d = digit_sel_q + 2'd1;
                if (digit_sel_q == 2'd3) snap_d = value;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_SHOW;
            cnt_q          <= '0;
            digit_sel_q    <= 2'd0;
            snap_q         <= 16'h0000;
            load_pending_q <= 1'b1;
            anode_q        <= 4'b1111;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            dsel_out_q     <= 2'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            digit_sel_q    <= digit_sel_d;
            snap_q         <= snap_d;
            load_pending_q <= load_pending_d;
            anode_q        <= anode_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            dsel_out_q     <= dsel_out_d;
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_sel = dsel_out_q;

endmodule

// File: tb/tb_seven_seg_display_controller.sv
// Bench for seven_seg_display_controller: two instances (with and without dead time) checked every
// cycle against a period-position model of the scan, plus directed checks of the key scenarios.
module tb_seven_seg_display_controller;

    localparam int TK = 4;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic        lz_suppress = 1'b0;

    logic [3:0] anode_a, anode_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [1:0] dsel_a, dsel_b;

    always #5 clk = ~clk;

    seven_seg_display_controller #(.CNT_W(17), .TICK_COUNT(TK), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .Reset(Reset), .en(en), .value(value), .dp_mask(dp_mask),
        .lz_suppress(lz_suppress), .anode(anode_a), .seg(seg_a), .dp(dp_a), .digit_sel(dsel_a)
    );

    seven_seg_display_controller #(.CNT_W(8), .TICK_COUNT(TK), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .Reset(Reset), .en(en), .value(value), .dp_mask(dp_mask),
        .lz_suppress(lz_suppress), .anode(anode_b), .seg(seg_b), .dp(dp_b), .digit_sel(dsel_b)
    );

    int tests = 0;
    int fails = 0;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: position within the per-digit period, current digit, latched frame value, pending load.
    int          m_pos [2];
    int          m_dig [2];
    logic        m_pend [2];
    logic [15:0] m_frame [2];

    logic [3:0] e_an [2];
    logic [6:0] e_seg [2];
    logic       e_dp [2];
    logic [1:0] e_dsel [2];

    function automatic int blank_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic model_reset(input int i);
        m_pos[i] = 0; m_dig[i] = 0; m_pend[i] = 1'b1; m_frame[i] = 16'h0000;
    endtask

    task automatic model_expect(input int i);
        logic [15:0] fv, hi;
        logic [3:0]  one;
        one = 4'b0001;
        e_an[i] = 4'b1111; e_seg[i] = 7'h7F; e_dp[i] = 1'b1;
        e_dsel[i] = Reset ? 2'd0 : 2'(m_dig[i]);
        if (!Reset && en && m_pos[i] < TK) begin
            fv = m_pend[i] ? value : m_frame[i];
            hi = fv >> (4 * m_dig[i]);
            e_an[i]  = ~(one << m_dig[i]);
            e_seg[i] = (lz_suppress && m_dig[i] != 0 && hi == 16'h0000) ? 7'h7F : segtab[hi[3:0]];
            e_dp[i]  = ~dp_mask[m_dig[i]];
        end
    endtask

    task automatic model_step(input int i);
        if (Reset) begin
            model_reset(i);
        end else if (en) begin
            if (m_pend[i]) begin m_frame[i] = value; m_pend[i] = 1'b0; end
            m_pos[i] = m_pos[i] + 1;
            if (m_pos[i] == TK + blank_of(i)) begin
                m_pos[i] = 0;
                m_dig[i] = (m_dig[i] + 1) % 4;
                if (m_dig[i] == 0) m_frame[i] = value;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: predict from pre-edge state and inputs, advance the model, check at the falling edge.
    task automatic cyc();
        model_expect(0);
        model_expect(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        chk("a.anode", 16'(anode_a), 16'(e_an[0]));
        chk("a.seg",   16'(seg_a),   16'(e_seg[0]));
        chk("a.dp",    16'(dp_a),    16'(e_dp[0]));
        chk("a.dsel",  16'(dsel_a),  16'(e_dsel[0]));
        chk("b.anode", 16'(anode_b), 16'(e_an[1]));
        chk("b.seg",   16'(seg_b),   16'(e_seg[1]));
        chk("b.dp",    16'(dp_b),    16'(e_dp[1]));
        chk("b.dsel",  16'(dsel_b),  16'(e_dsel[1]));
    endtask

    task automatic run_until(input int dig, input int pos, input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (m_dig[0] == dig && m_pos[0] == pos) begin ok = 1'b1; break; end
            cyc();
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL %s: position d%0d/p%0d not reached, at d%0d/p%0d", tag, dig, pos, m_dig[0], m_pos[0]);
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Basic scan of 1234 out of reset
        en = 1'b1; value = 16'h1234;
        repeat (2) cyc();
        Reset = 1'b0;
        cyc();
        chk("first_anode", 16'(anode_a), 16'h000E);
        chk("first_seg",   16'(seg_a),   16'h0019);
        repeat (47) cyc();

        // No dead time on instance b, value ABCD
        value = 16'hABCD;
        repeat (48) cyc();

        // Leading-zero suppression and decimal point
        value = 16'h0005; lz_suppress = 1'b1; dp_mask = 4'b0100;
        repeat (48) cyc();
        lz_suppress = 1'b0;
        repeat (24) cyc();

        // Mid-frame value change shows only from the next frame
        dp_mask = 4'b0000; value = 16'h1111;
        repeat (48) cyc();
        run_until(1, 0, "reach_d1");
        value = 16'h2222;
        cyc();
        chk("old_frame_seg", 16'(seg_a), 16'h0079);
        run_until(0, 0, "reach_d0");
        cyc();
        chk("new_frame_seg", 16'(seg_a), 16'h0024);

        // Enable dropped during SHOW of digit 2 at count 1
        run_until(2, 1, "reach_d2c1");
        en = 1'b0;
        repeat (10) cyc();
        chk("gap_anode", 16'(anode_a), 16'h000F);
        en = 1'b1;
        repeat (3) begin
            cyc();
            chk("resume_anode", 16'(anode_a), 16'h000B);
        end
        cyc();
        chk("resume_blank", 16'(anode_a), 16'h000F);

        // Asynchronous reset during BLANK of digit 3
        run_until(3, TK, "reach_d3blank");
        #2 Reset = 1'b1;
        #1;
        chk("rst_anode_a", 16'(anode_a), 16'h000F);
        chk("rst_seg_a",   16'(seg_a),   16'h007F);
        chk("rst_dp_a",    16'(dp_a),    16'h0001);
        chk("rst_dsel_a",  16'(dsel_a),  16'h0000);
        chk("rst_anode_b", 16'(anode_b), 16'h000F);
        chk("rst_dsel_b",  16'(dsel_b),  16'h0000);
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        cyc();
        value = 16'h8765;
        Reset = 1'b0;
        cyc();
        chk("post_rst_anode", 16'(anode_a), 16'h000E);
        chk("post_rst_seg",   16'(seg_a),   16'h0012);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0:       value = 16'($urandom);
                    1:       value = 16'($urandom) & 16'h0FFF;
                    2:       value = 16'($urandom) & 16'h00FF;
                    3:       value = 16'($urandom) & 16'h000F;
                    default: value = 16'h0000;
                endcase
            end
            if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 7) == 0) lz_suppress = 1'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_display_controller.md
Name: seven_seg_display_controller

Overview:
Time-multiplexes one shared, active-low segment bus across four common-anode digits. It sequences the digit scanner, holds a per-frame snapshot of the 16-bit display value, decodes hex to segments, and applies leading-zero suppression and decimal points. A dead-time blanking interval between digits prevents ghosting. Sits between the datapath/math result registers and the board's display pins.

Parameters:
CNT_W, 17, width of the shared phase counter
TICK_COUNT, 100000, clk cycles each digit is lit (SHOW phase); legal range 2..2^CNT_W-1
BLANK_CYCLES, 1000, clk cycles all anodes are off between digits (BLANK phase); legal range 0..TICK_COUNT-1

Ports:
clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
en  input  1  display enable; 0 = all anodes off, sequencing frozen
value  input  16  four hex nibbles; value[4k+3:4k] drives digit k (digit 0 = rightmost)
dp_mask  input  4  bit k=1 lights the decimal point on digit k
lz_suppress  input  1  1 = blank leading zero digits
anode  output  4  active-low digit enables
seg  output  7  active-low segments {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point
digit_sel  output  2  index of the digit currently owning the bus

Behaviour:
- Reset (async, immediate): anode=4'b1111, seg=7'h7F, dp=1, digit_sel=0, FSM=SHOW, counter=0, snapshot=16'h0000, load_pending=1.
- All outputs are registered and reflect the state one clk later.
- FSM states:
  - SHOW: the digit given by digit_sel is lit; the counter counts 0..TICK_COUNT-1. At terminal count the counter clears and the FSM goes to BLANK. If BLANK_CYCLES=0, it skips BLANK and advances the digit directly.
  - BLANK: anode=4'b1111, seg=7'h7F, dp=1; the counter counts 0..BLANK_CYCLES-1. At terminal count the counter clears, digit_sel increments mod 4 (0→1→2→3→0), and the FSM goes to SHOW.
- Per-digit period is TICK_COUNT+BLANK_CYCLES cycles; frame period is 4× that.
- Snapshot: value is captured into snapshot on the clk edge that enters SHOW for digit 0 (the 3→0 wrap). It is also captured on the first enabled clk with load_pending=1, which then clears load_pending. This prevents tearing within a frame; mid-frame changes to value appear only from the next frame.
- dp_mask and lz_suppress are not snapshotted; they are sampled live.
- Anode in SHOW: anode = ~(4'b0001 << digit_sel). Exactly one anode is low.
- Decode of nibble n (hex 0-F, active low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Leading-zero suppression: digit k (k=1..3) is suppressed when lz_suppress=1 and snapshot nibbles k..3 are all zero. Digit 0 is never suppressed.
  - A suppressed digit drives seg=7'h7F; its anode is still driven and dp still follows dp_mask.
- dp in SHOW = ~dp_mask[digit_sel].
- en=0: counter, FSM, digit_sel and snapshot hold. Outputs go to anode=4'b1111, seg=7'h7F, dp=1 on the next clk.
- Re-asserting en resumes from the held state and count, with no digit skipped or repeated.
- Reset mid-phase aborts immediately to the reset state regardless of the current phase.

Test Plan:
1. TICK_COUNT=4, BLANK_CYCLES=2, en=1, value=16'h1234, release Reset → anode sequence 1110 (4 clk), 1111 (2), 1101 (4), 1111 (2), 1011, 1111, 0111, 1111, 1110, repeating. seg while digit 0 lit = 7'h19, digit 3 = 7'h79. digit_sel tracks 0,1,2,3.
2. BLANK_CYCLES=0, value=16'hABCD → no 1111 gaps. Each digit lit 4 cycles; seg cycles 7'h21, 7'h46, 7'h03, 7'h08.
3. value=16'h0005, lz_suppress=1, dp_mask=4'b0100 → digit 0 seg=7'h12; digits 1-3 seg=7'h7F with anodes still sequencing; dp=0 only while digit 2 is lit. Repeat with lz_suppress=0 → digits 1-3 seg=7'h40.
4. value changed 16'h1111→16'h2222 while digit 1 is lit → digits 1-3 of the current frame still show 7'h79. From the next digit-0 SHOW onward, all digits show 7'h24.
5. en dropped for 10 clk during SHOW of digit 2 at count 1 → anode=1111 during the gap. After re-enable, digit 2 is lit for the remaining 3 cycles, then BLANK.
6. Reset asserted asynchronously mid-BLANK of digit 3 → outputs go to reset values without waiting for clk. After release, digit 0 is lit with the freshly loaded snapshot.
